// File: rtl/sha256d_nonce_scheduler_if.sv
// sha256d_nonce_scheduler_if: issue/completion bus between the nonce scheduler and the core array.
interface sha256d_nonce_scheduler_if #(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = 32
);
   logic [NUM_CORES-1:0] core_start;
   logic [NONCE_W-1:0]   core_nonce;
   logic [NUM_CORES-1:0] core_done;
   logic [NUM_CORES-1:0] core_hit;
   modport master (output core_start, core_nonce, input core_done, core_hit);
   modport slave  (input core_start, core_nonce, output core_done, core_hit);
endinterface

// File: rtl/sha256d_nonce_scheduler.sv
// sha256d_nonce_scheduler: round-robin nonce dispatch to NUM_CORES sha256d cores, first-hit capture and completion pulse.
module sha256d_nonce_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int NONCE_W   = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                start,
   input  logic                abort,
   input  logic [NONCE_W-1:0]  nonce_first,
   input  logic [NONCE_W-1:0]  nonce_last,
   sha256d_nonce_scheduler_if.master cores,
   output logic                busy,
   output logic                done_intr,
   output logic [1:0]          status,
   output logic [NONCE_W-1:0]  found_nonce,
   output logic [NONCE_W:0]    hashes_done
);
   localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_t;
   state_t               state;
   logic [NUM_CORES-1:0] pend, fin, hits, gnt_hot;
   logic [NONCE_W-1:0]   nxt, last;
   logic [NONCE_W-1:0]   nonce_reg [NUM_CORES];
   logic                 exhausted, gnt_ok, issue;
   logic [PW-1:0]        ptr, gnt, gnt_nxt, hit_idx;
   logic [PW:0]          idx;
   logic [NONCE_W:0]     cnt;
   assign fin     = cores.core_done & pend;
   assign hits    = fin & cores.core_hit;
   assign issue   = state == DISPATCH && !exhausted && gnt_ok && hits == '0 && !abort;
   assign gnt_hot = issue ? NUM_CORES'(1) << gnt : '0;
   assign gnt_nxt = gnt == PW'(NUM_CORES - 1) ? '0 : gnt + 1'b1;
   // ptr is the first index searched, i.e. one past the last granted core
   always_comb begin
      gnt_ok  = 1'b0;
      gnt     = '0;
      idx     = '0;
      hit_idx = '0;
      cnt     = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
         idx = (PW+1)'(ptr) + (PW+1)'(j);
         idx = idx >= (PW+1)'(NUM_CORES) ? idx - (PW+1)'(NUM_CORES) : idx;
         if (!gnt_ok && !pend[idx[PW-1:0]]) begin
            gnt_ok = 1'b1;
            gnt    = idx[PW-1:0];
         end
      end
      for (int i = NUM_CORES - 1; i >= 0; i--)
         if (hits[i]) hit_idx = PW'(i);
      for (int i = 0; i < NUM_CORES; i++)
         cnt = cnt + (NONCE_W+1)'(fin[i]);
   end
   always_ff @(posedge ACLK)
      if (issue) nonce_reg[gnt] <= nxt;
   always_ff @(posedge ACLK or posedge ARESET)
      if (ARESET) begin
         state            <= IDLE;
         cores.core_start <= '0;
         cores.core_nonce <= '0;
         busy             <= 1'b0;
         done_intr        <= 1'b0;
         status           <= 2'b00;
         found_nonce      <= '0;
         hashes_done      <= '0;
         pend             <= '0;
         ptr              <= '0;
         nxt              <= '0;
         last             <= '0;
         exhausted        <= 1'b0;
      end else begin
         cores.core_start <= gnt_hot;
         done_intr        <= 1'b0;
         pend             <= (pend & ~fin) | gnt_hot;
         hashes_done      <= hashes_done + cnt;
         if (issue) begin
            cores.core_nonce <= nxt;
            ptr              <= gnt_nxt;
            if (nxt == last) exhausted <= 1'b1;
            else nxt <= nxt + 1'b1;
         end
         // first hit wins, including one that lands during drain
         if (hits != '0 && status != 2'b01) begin
            found_nonce <= nonce_reg[hit_idx];
            status      <= 2'b01;
         end
         case (state)
            IDLE: if (start) begin
               state       <= DISPATCH;
               busy        <= 1'b1;
               nxt         <= nonce_first;
               last        <= nonce_last;
               exhausted   <= nonce_first > nonce_last;
               pend        <= '0;
               hashes_done <= '0;
               status      <= 2'b00;
               found_nonce <= '0;
            end
            DISPATCH: if (hits != '0 || abort || exhausted) begin
               state <= DRAIN;
               if (hits == '0) status <= abort ? 2'b11 : 2'b10;
            end
            DRAIN: if (pend == '0) begin
               state     <= FINISH;
               done_intr <= 1'b1;
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule

// File: doc/sha256d_nonce_scheduler.md
# sha256d_nonce_scheduler

Shares NUM_CORES sha256d hashing cores across one nonce search job. Hands out consecutive nonces from a programmed range to idle cores in round-robin order and tracks outstanding work. Stops on first hit, range exhaustion or abort, then raises a completion pulse for the AXI interrupt block. Sits between the AXI-Lite register file, which supplies the job config, and the core array inside multi_sha256d_axi_ip_intr.

## Interface
- NUM_CORES, 4, number of hashing cores served (2..16).
- NONCE_W, 32, nonce width.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  job start pulse; honoured only in IDLE, ignored otherwise.
- abort  in  1  level or pulse; stops dispatch while in DISPATCH.
- nonce_first  in  NONCE_W  first nonce of range, sampled on accepted start.
- nonce_last  in  NONCE_W  last nonce of range (inclusive), sampled on accepted start.
- core_start  out  NUM_CORES  one-hot, one-cycle issue strobe.
- core_nonce  out  NONCE_W  nonce for the core strobed this cycle; shared bus.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_hit  in  NUM_CORES  per-core hit flag, valid only with core_done.
- busy  out  1  high in every state except IDLE.
- done_intr  out  1  one-cycle pulse on job completion.
- status  out  2  00 none, 01 found, 10 exhausted, 11 aborted; held until next start.
- found_nonce  out  NONCE_W  nonce of the first hit; valid when status=01.
- hashes_done  out  NONCE_W+1  count of completed nonces for the current job.

## Operation
- States: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE + start: latch range, next=nonce_first, exhausted=(nonce_first>nonce_last), clear pend, hashes_done, status, found_nonce, go DISPATCH.
- Internal pend[NUM_CORES] marks cores with an outstanding nonce; per-core nonce register holds the nonce issued to it.
- DISPATCH, each cycle: if !exhausted and a core with pend=0 exists, grant one core by round-robin.
  - Search starts at the index after the last granted core; after reset the search starts at 0.
  - Drive core_start[g]=1 and core_nonce=next, set pend[g], and store the nonce for core g.
  - If next==nonce_last, set exhausted; else next+=1. The exhausted flag prevents wrap when nonce_last is all-ones.
- DISPATCH exits to DRAIN on any of: exhausted with no further issue possible; a hit; abort.
- The reason is recorded in status. Priority in the same cycle: found > aborted > exhausted.
- A core is not re-issued in the same cycle its core_done arrives; it becomes eligible the next cycle.
- core_done[i] with pend[i]=1: clear pend[i] and increment hashes_done.
  - If core_hit[i] and no hit is latched yet, latch found_nonce from core i's register and set status=01.
  - Several simultaneous hits: the lowest index wins. Hits after the first are counted but ignored.
- core_done[i] with pend[i]=0: ignored entirely, no count.
- Hits arriving in DRAIN are still latched if none is latched yet. If that happens, status is upgraded to 01 even if the exit reason was exhausted or abort.
- DRAIN: no issue. When pend==0, go FINISH.
- FINISH: done_intr=1 for exactly one cycle, then IDLE.
- abort in IDLE, DRAIN or FINISH has no effect.
- An empty range (nonce_first>nonce_last) goes DISPATCH→DRAIN→FINISH with zero issues, status=10, hashes_done=0.

## Timing
- Reset values: state IDLE, core_start=0, core_nonce=0, busy=0, done_intr=0, status=00, found_nonce=0, hashes_done=0, pend=0, round-robin pointer=0.
- ARESET mid-job returns to reset values immediately. Outstanding core results are dropped.
- All outputs are registered.
- start accepted at edge k: busy=1 and state DISPATCH after edge k. First core_start is asserted after edge k+1.
- At most one issue per cycle. NUM_CORES cores are filled in NUM_CORES consecutive cycles.
- core_done at edge m: counted and pend cleared by edge m. Core eligible for issue at edge m+1.
- Completion: last pend clear at edge m → FINISH after edge m+1 (done_intr high) → IDLE and busy=0 after edge m+2.

## Test plan
- Range 0x10..0x13, NUM_CORES=4, cores complete after 8 cycles with no hits:
  - core_start one-hot 0001,0010,0100,1000 on 4 consecutive cycles with nonces 0x10..0x13.
  - Then one done_intr pulse; status=10, hashes_done=4.
- Range 0..99, core 2 hits on nonce 0x22:
  - Issue stops next cycle; outstanding cores drain.
  - status=01, found_nonce=0x22, done_intr pulses once.
- Two cores assert core_done+core_hit in the same cycle → found_nonce is the lower-index core's nonce.
- Range 0xFFFFFFFE..0xFFFFFFFF → exactly 2 issues, no wrap to 0; status=10, hashes_done=2.
- nonce_first=5, nonce_last=4 → no core_start; done_intr 3 cycles after start; status=10, hashes_done=0.
- Abort after 3 issues:
  - No further core_start; done_intr pulses after the 3 dones; status=11, hashes_done=3.
  - Separately: ARESET mid-DRAIN → all outputs at reset values; a subsequent start runs normally.
